elevator_ctrl: RTL and testbench



---
 rtl/elevator_ctrl.sv | 146 ++++++++++++++
 tb/tb_elevator_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl.sv
// Four-floor SCAN elevator sequencer: latches call buttons, times floor travel (MOVE_TICKS) and door dwell (DOOR_TICKS).
// All outputs are flops (one-cycle latency from req to pending); calls are always accepted, no backpressure.
module elevator_ctrl #(
    parameter int MOVE_TICKS = 50_000_000,
    parameter int DOOR_TICKS = 100_000_000,
    parameter int CNT_W      = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] floor,
    output logic [1:0] state,
    output logic       door_open,
    output logic [3:0] pending
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DOOR = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MOVE_LOAD = CNT_W'(MOVE_TICKS - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_TICKS - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE = CNT_W'(1);

    state_t           state_q, state_d, move_d;
    logic [1:0]       floor_q, floor_d, nf, dec_floor;
    logic [3:0]       pending_q, pending_d, clr;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             dir_q, dir_d;
    logic             door_q;
    logic             above, below, here, moving;

    function automatic logic [3:0] mask_above(input logic [1:0] f);
        case (f)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1100;
            2'd2:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] mask_below(input logic [1:0] f);
        case (f)
            2'd0:    return 4'b0000;
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic state_t pick_move(input logic a, input logic b, input logic up);
        if (a && b) return up ? S_UP : S_DOWN;
        if (a)      return S_UP;
        if (b)      return S_DOWN;
        return S_IDLE;
    endfunction

    // While moving, every decision is made against the floor being arrived at.
    assign moving    = (state_q == S_UP) || (state_q == S_DOWN);
    assign nf        = (state_q == S_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
    assign dec_floor = moving ? nf : floor_q;
    assign above     = |(pending_q & mask_above(dec_floor));
    assign below     = |(pending_q & mask_below(dec_floor));
    assign here      = pending_q[dec_floor];
    assign move_d    = pick_move(above, below, dir_q);

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        timer_d = timer_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (here) begin
                    state_d = S_DOOR;
                    timer_d = DOOR_LOAD;
                end else begin
                    state_d = move_d;
                    if (move_d != S_IDLE) begin
                        timer_d = MOVE_LOAD;
                        dir_d   = (move_d == S_UP);
                    end
                end
            end
            S_UP, S_DOWN: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_ONE;
                end else begin
                    floor_d = nf;
                    if (here) begin
                        state_d = S_DOOR;
                        timer_d = DOOR_LOAD;
                    end else begin
                        state_d = move_d;
                        if (move_d != S_IDLE) begin
                            timer_d = MOVE_LOAD;
                            dir_d   = (move_d == S_UP);
                        end
                    end
                end
            end
            S_DOOR: begin
                // A press at the open floor re-opens the door instead of latching a call.
                if (req[floor_q]) begin
                    timer_d = DOOR_LOAD;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_ONE;
                end else begin
                    state_d = move_d;
                    if (move_d != S_IDLE) begin
                        timer_d = MOVE_LOAD;
                        dir_d   = (move_d == S_UP);
                    end
                end
            end
        endcase
    end

    assign clr       = ((state_q == S_DOOR) || (state_d == S_DOOR)) ? (4'b0001 << dec_floor) : 4'b0000;
    assign pending_d = (pending_q | req) & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            floor_q   <= 2'd0;
            pending_q <= 4'b0000;
            timer_q   <= '0;
            dir_q     <= 1'b1;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            dir_q     <= dir_d;
            door_q    <= (state_d == S_DOOR);
        end
    end

    assign floor     = floor_q;
    assign state     = state_q;
    assign door_open = door_q;
    assign pending   = pending_q;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed scenarios against hand-derived timelines, then random calls against a reference model.
module tb_elevator_ctrl;
    localparam int MOVE_TICKS = 4;
    localparam int DOOR_TICKS = 6;
    localparam int CNT_W      = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [1:0] floor;
    logic [1:0] state;
    logic       door_open;
    logic [3:0] pending;
    logic [8:0] obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elevator_ctrl #(
        .MOVE_TICKS(MOVE_TICKS),
        .DOOR_TICKS(DOOR_TICKS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .floor    (floor),
        .state    (state),
        .door_open(door_open),
        .pending  (pending)
    );

    assign obs = {floor, state, pending, door_open};

    function automatic logic [8:0] pk(input int f, input int s, input logic [3:0] p, input logic d);
        return {2'(f), 2'(s), p, d};
    endfunction

    // Reference model: floors as integers, direction as +1/-1, one SCAN rule for every decision.
    int         m_floor = 0;
    int         m_state = 0;
    int         m_timer = 0;
    int         m_dir   = 1;
    int         m_go;
    int         m_clr;
    logic [3:0] m_pend  = 4'b0000;
    logic [3:0] m_old;

    function automatic int pick_dir(input logic [3:0] p, input int f, input int d);
        int up = 0;
        int dn = 0;
        for (int i = 0; i < 4; i++) begin
            if (p[i] && i > f) up++;
            if (p[i] && i < f) dn++;
        end
        if (up > 0 && dn > 0) return d;
        if (up > 0) return 1;
        if (dn > 0) return -1;
        return 0;
    endfunction

    task automatic model_launch();
        m_go = pick_dir(m_old, m_floor, m_dir);
        if (m_go == 0) begin
            m_state = 0;
        end else begin
            m_dir   = m_go;
            m_state = (m_go > 0) ? 1 : 2;
            m_timer = MOVE_TICKS - 1;
        end
    endtask

    task automatic model_open();
        m_state = 3;
        m_timer = DOOR_TICKS - 1;
        m_clr   = m_floor;
    endtask

    task automatic model_step();
        if (rst) begin
            m_floor = 0; m_state = 0; m_timer = 0; m_dir = 1; m_pend = 4'b0000;
        end else begin
            m_old = m_pend;
            m_clr = -1;
            if (m_state == 0) begin
                if (m_old[m_floor]) model_open();
                else model_launch();
            end else if (m_state == 1 || m_state == 2) begin
                if (m_timer == 0) begin
                    m_floor = m_floor + m_dir;
                    if (m_old[m_floor]) model_open();
                    else model_launch();
                end else begin
                    m_timer--;
                end
            end else begin
                m_clr = m_floor;
                if (req[m_floor]) m_timer = DOOR_TICKS - 1;
                else if (m_timer == 0) model_launch();
                else m_timer--;
            end
            m_pend = m_old | req;
            if (m_clr >= 0) m_pend[m_clr] = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    task automatic pulse(input logic [3:0] r);
        req = r;
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!(state == 2'd0 && pending == 4'b0000) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(state == 2'd0 && pending == 4'b0000)) begin
            errors++;
            $display("FAIL %s: not idle after %0d cycles (state=%0d pending=%b)", tag, n, state, pending);
        end
    endtask

    task automatic wait_door(input int budget, input int want_floor, input string tag);
        int n = 0;
        while (!door_open && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(door_open === 1'b1 && floor === 2'(want_floor))) begin
            errors++;
            $display("FAIL %s: door=%b floor=%0d after %0d cycles, want door=1 floor=%0d",
                     tag, door_open, floor, n, want_floor);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 9'h000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got f=%0d s=%0d p=%b d=%b, want all zero",
                         i, floor, state, pending, door_open);
            end
        end
        rst = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (obs !== 9'h000) begin
            errors++;
            $display("FAIL reset_release: got f=%0d s=%0d p=%b d=%b, want all zero",
                     floor, state, pending, door_open);
        end
    endtask

    task automatic test_single_up();
        int         ks[8] = '{0, 1, 4, 5, 8, 9, 14, 15};
        logic [8:0] ev[8];
        int         idx = 0;
        ev = '{pk(0, 0, 4'b0100, 1'b0), pk(0, 1, 4'b0100, 1'b0), pk(0, 1, 4'b0100, 1'b0),
               pk(1, 1, 4'b0100, 1'b0), pk(1, 1, 4'b0100, 1'b0), pk(2, 3, 4'b0000, 1'b1),
               pk(2, 3, 4'b0000, 1'b1), pk(2, 0, 4'b0000, 1'b0)};
        req = 4'b0100;
        for (int k = 0; k <= 15; k++) begin
            @(negedge clk);
            req = 4'b0000;
            if (k == ks[idx]) begin
                checks++;
                if (obs !== ev[idx]) begin
                    errors++;
                    $display("FAIL single_up t+%0d: got %b want %b (floor,state,pending,door)", k, obs, ev[idx]);
                end
                if (idx < 7) idx++;
            end
        end
    endtask

    task automatic test_call_here();
        logic [8:0] exp;
        pulse(4'b0010);
        wait_idle(60, "call_here_setup");
        req = 4'b0010;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            req = 4'b0000;
            if (k == 0) exp = pk(1, 0, 4'b0010, 1'b0);
            else if (k < 7) exp = pk(1, 3, 4'b0000, 1'b1);
            else exp = pk(1, 0, 4'b0000, 1'b0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL call_here t+%0d: got %b want %b (floor,state,pending,door)", k, obs, exp);
            end
        end
    endtask

    task automatic test_scan();
        int         ks[15] = '{1, 5, 6, 9, 10, 13, 14, 19, 20, 24, 28, 31, 32, 37, 38};
        logic [8:0] ev[15];
        int         idx = 0;
        ev = '{pk(1, 3, 4'b1001, 1'b1), pk(1, 3, 4'b1001, 1'b1), pk(1, 1, 4'b1001, 1'b0),
               pk(1, 1, 4'b1001, 1'b0), pk(2, 1, 4'b1001, 1'b0), pk(2, 1, 4'b1001, 1'b0),
               pk(3, 3, 4'b0001, 1'b1), pk(3, 3, 4'b0001, 1'b1), pk(3, 2, 4'b0001, 1'b0),
               pk(2, 2, 4'b0001, 1'b0), pk(1, 2, 4'b0001, 1'b0), pk(1, 2, 4'b0001, 1'b0),
               pk(0, 3, 4'b0000, 1'b1), pk(0, 3, 4'b0000, 1'b1), pk(0, 0, 4'b0000, 1'b0)};
        pulse(4'b0001);
        wait_idle(60, "scan_setup_floor0");
        pulse(4'b0010);
        wait_door(20, 1, "scan_setup_door1");
        req = 4'b1001;
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            req = 4'b0000;
            if (k == ks[idx]) begin
                checks++;
                if (obs !== ev[idx]) begin
                    errors++;
                    $display("FAIL scan t+%0d: got %b want %b (floor,state,pending,door)", k, obs, ev[idx]);
                end
                if (idx < 14) idx++;
            end
        end
    endtask

    task automatic test_reopen();
        logic [8:0] exp;
        pulse(4'b0100);
        wait_door(30, 2, "reopen_setup");
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            exp = (k < 10) ? pk(2, 3, 4'b0000, 1'b1) : pk(2, 0, 4'b0000, 1'b0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reopen dwell %0d: got %b want %b (floor,state,pending,door)", k, obs, exp);
            end
            req = (k == 3) ? 4'b0100 : 4'b0000;
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_move();
        pulse(4'b0010);
        wait_idle(60, "midmove_setup");
        pulse(4'b1000);
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== pk(1, 1, 4'b1000, 1'b0)) begin
            errors++;
            $display("FAIL midmove_before: got %b want %b", obs, pk(1, 1, 4'b1000, 1'b0));
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 9'h000) begin
            errors++;
            $display("FAIL midmove_async_reset: got %b want 000000000", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== 9'h000) begin
                errors++;
                $display("FAIL midmove_after_release %0d: got %b want 000000000", k, obs);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] exp;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            exp = pk(m_floor, m_state, m_pend, (m_state == 3));
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: got %b want %b (floor,state,pending,door)", c, obs, exp);
            end
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
            req = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
        end
        rst = 1'b0;
        req = 4'b0000;
    endtask

    initial begin
        rst = 1'b0;
        req = 4'b0000;
        #1;
        rst = 1'b1;
        req = 4'b1111;
        test_reset();
        test_single_up();
        test_call_here();
        test_scan();
        test_reopen();
        test_reset_mid_move();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
